exu_longp_oitf_arb: RTL and testbench

//  Orders long-pipe writebacks (LSU, MUL/DIV, ...) to the register file.

---
 rtl/exu_longp_oitf_arb_pkg.sv | 19 +
 rtl/exu_oitf.sv | 93 +++++++++
 rtl/exu_longp_oitf_arb.sv | 112 +++++++++++
 tb/tb_exu_longp_oitf_arb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_longp_oitf_arb_pkg.sv
// Shared definitions for the long-pipe writeback arbiter and its OITF.
//   FLEN / RFIDX_WIDTH : result and register-index widths
//   LONGP_UNIT_*       : unit ids of the long-pipe requesters
//   reg_hit()          : one source/destination compare used by the hazard check
package exu_longp_oitf_arb_pkg;

  localparam int FLEN              = 32;
  localparam int RFIDX_WIDTH       = 5;
  localparam int LONGP_UNIT_LSU    = 0;
  localparam int LONGP_UNIT_MULDIV = 1;

  typedef logic [RFIDX_WIDTH-1:0] rfidx_t;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic en, input rfidx_t src, input rfidx_t rd);
    return en & (src == rd) & (rd != '0);
  endfunction

endpackage

// File: rtl/exu_oitf.sv
// Outstanding-instruction FIFO for long-pipe ops.
//   push/push_*      : log a dispatched op at the write pointer
//   pop              : retire the head entry
//   full/empty       : occupancy flags (pointers carry a wrap bit)
//   wptr_idx/rptr_idx: itag of the next push / of the head
//   head_*           : fields of the head entry
//   chk_*/dep        : RAW/WAW compare of a dispatching op against registered entries
module exu_oitf
  import exu_longp_oitf_arb_pkg::*;
#(
  parameter int OITF_DEPTH = 4,
  parameter int UID_W      = 1,
  localparam int PTR_W     = $clog2(OITF_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UID_W-1:0]       push_unit,
  input  logic                   push_rdwen,
  input  logic [RFIDX_WIDTH-1:0] push_rdidx,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [PTR_W-1:0]       wptr_idx,
  output logic [PTR_W-1:0]       rptr_idx,
  output logic [UID_W-1:0]       head_unit,
  output logic                   head_rdwen,
  output logic [RFIDX_WIDTH-1:0] head_rdidx,
  input  logic                   chk_rs1en,
  input  logic [RFIDX_WIDTH-1:0] chk_rs1idx,
  input  logic                   chk_rs2en,
  input  logic [RFIDX_WIDTH-1:0] chk_rs2idx,
  input  logic                   chk_rdwen,
  input  logic [RFIDX_WIDTH-1:0] chk_rdidx,
  output logic                   dep
);

  logic [PTR_W:0]           wptr;
  logic [PTR_W:0]           rptr;
  logic [OITF_DEPTH-1:0]    vld;
  logic [UID_W-1:0]         unit_q  [OITF_DEPTH];
  logic                     rdwen_q [OITF_DEPTH];
  logic [RFIDX_WIDTH-1:0]   rdidx_q [OITF_DEPTH];

  assign wptr_idx = wptr[PTR_W-1:0];
  assign rptr_idx = rptr[PTR_W-1:0];
  assign empty    = (wptr == rptr);
  assign full     = (wptr_idx == rptr_idx) & (wptr[PTR_W] != rptr[PTR_W]);

  // Control state: pointers and valid bits. A push never lands on the head
  // slot while it is being popped (that slot is only free when empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      vld  <= '0;
    end else begin
      if (pop) begin
        vld[rptr_idx] <= 1'b0;
        rptr          <= rptr + (PTR_W+1)'(1);
      end
      if (push) begin
        vld[wptr_idx] <= 1'b1;
        wptr          <= wptr + (PTR_W+1)'(1);
      end
    end
  end

  // Entry payload: only meaningful while vld is set.
  always_ff @(posedge clk) begin
    if (push) begin
      unit_q[wptr_idx]  <= push_unit;
      rdwen_q[wptr_idx] <= push_rdwen;
      rdidx_q[wptr_idx] <= push_rdidx;
    end
  end

  assign head_unit  = unit_q[rptr_idx];
  assign head_rdwen = rdwen_q[rptr_idx];
  assign head_rdidx = rdidx_q[rptr_idx];

  always_comb begin
    dep = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (vld[i] & rdwen_q[i]) begin
        dep = dep | reg_hit(chk_rs1en, chk_rs1idx, rdidx_q[i])
                  | reg_hit(chk_rs2en, chk_rs2idx, rdidx_q[i])
                  | reg_hit(chk_rdwen, chk_rdidx,  rdidx_q[i]);
      end
    end
  end

endmodule

// File: rtl/exu_longp_oitf_arb.sv
// Long-pipe writeback arbiter: logs long-pipe ops in dispatch order and only
// lets the unit owning the OITF head (with the matching itag) write back.
//   disp_*          : dispatch handshake, itag return and hazard flag
//   unit_wbck_*     : per-unit results (packed, unit i at slice i)
//   longp_wbck_o_*  : head result forwarded to the register-file writeback
//   oitf_empty      : nothing outstanding
module exu_longp_oitf_arb
  import exu_longp_oitf_arb_pkg::*;
#(
  parameter int OITF_DEPTH = 4,
  parameter int NUM_UNITS  = 2,
  localparam int PTR_W     = $clog2(OITF_DEPTH),
  localparam int UID_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [UID_W-1:0]           disp_unit,
  input  logic                       disp_rdwen,
  input  logic [RFIDX_WIDTH-1:0]     disp_rdidx,
  output logic [PTR_W-1:0]           disp_itag,
  input  logic                       disp_rs1en,
  input  logic                       disp_rs2en,
  input  logic [RFIDX_WIDTH-1:0]     disp_rs1idx,
  input  logic [RFIDX_WIDTH-1:0]     disp_rs2idx,
  output logic                       disp_dep,
  input  logic [NUM_UNITS-1:0]       unit_wbck_valid,
  output logic [NUM_UNITS-1:0]       unit_wbck_ready,
  input  logic [NUM_UNITS*FLEN-1:0]  unit_wbck_wdat,
  input  logic [NUM_UNITS*PTR_W-1:0] unit_wbck_itag,
  output logic                       longp_wbck_o_valid,
  input  logic                       longp_wbck_o_ready,
  output logic [FLEN-1:0]            longp_wbck_o_wdat,
  output logic [RFIDX_WIDTH-1:0]     longp_wbck_o_rdidx,
  output logic                       oitf_empty
);

  logic                   oitf_full;
  logic                   push;
  logic                   pop;
  logic [PTR_W-1:0]       rptr_idx;
  logic [UID_W-1:0]       head_unit;
  logic                   head_rdwen;
  logic [RFIDX_WIDTH-1:0] head_rdidx;
  logic                   sel_valid;
  logic [PTR_W-1:0]       sel_itag;
  logic [FLEN-1:0]        sel_wdat;
  logic                   match;

  // Full blocks dispatch outright; a same-cycle pop does not free a slot early.
  assign disp_ready = ~oitf_full;
  assign push       = disp_valid & disp_ready;

  exu_oitf #(
    .OITF_DEPTH (OITF_DEPTH),
    .UID_W      (UID_W)
  ) u_oitf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_unit  (disp_unit),
    .push_rdwen (disp_rdwen),
    .push_rdidx (disp_rdidx),
    .pop        (pop),
    .full       (oitf_full),
    .empty      (oitf_empty),
    .wptr_idx   (disp_itag),
    .rptr_idx   (rptr_idx),
    .head_unit  (head_unit),
    .head_rdwen (head_rdwen),
    .head_rdidx (head_rdidx),
    .chk_rs1en  (disp_rs1en),
    .chk_rs1idx (disp_rs1idx),
    .chk_rs2en  (disp_rs2en),
    .chk_rs2idx (disp_rs2idx),
    .chk_rdwen  (disp_rdwen),
    .chk_rdidx  (disp_rdidx),
    .dep        (disp_dep)
  );

  // Head-unit mux: the data path is always driven so outputs stay defined.
  always_comb begin
    sel_valid = 1'b0;
    sel_itag  = '0;
    sel_wdat  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (head_unit == UID_W'(i)) begin
        sel_valid = unit_wbck_valid[i];
        sel_itag  = unit_wbck_itag[i*PTR_W +: PTR_W];
        sel_wdat  = unit_wbck_wdat[i*FLEN +: FLEN];
      end
    end
  end

  // The itag check keeps a unit from retiring a younger op of its own early.
  assign match = ~oitf_empty & sel_valid & (sel_itag == rptr_idx);

  // Ops without a destination (stores) retire without touching exu_wbck.
  assign pop                = match & (~head_rdwen | longp_wbck_o_ready);
  assign longp_wbck_o_valid = match & head_rdwen;
  assign longp_wbck_o_wdat  = sel_wdat;
  assign longp_wbck_o_rdidx = head_rdidx;

  always_comb begin
    unit_wbck_ready = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_wbck_ready[i] = pop & (head_unit == UID_W'(i));
    end
  end

endmodule

// File: tb/tb_exu_longp_oitf_arb.sv
module tb_exu_longp_oitf_arb;
  import exu_longp_oitf_arb_pkg::*;

  localparam int D  = 4;
  localparam int N  = 2;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_valid, disp_ready, disp_unit, disp_rdwen;
  logic [4:0]    disp_rdidx, disp_rs1idx, disp_rs2idx;
  logic [PW-1:0] disp_itag;
  logic          disp_rs1en, disp_rs2en, disp_dep;
  logic [N-1:0]  unit_wbck_valid, unit_wbck_ready;
  logic [N*32-1:0] unit_wbck_wdat;
  logic [N*PW-1:0] unit_wbck_itag;
  logic          longp_wbck_o_valid, longp_wbck_o_ready;
  logic [31:0]   longp_wbck_o_wdat;
  logic [4:0]    longp_wbck_o_rdidx;
  logic          oitf_empty;

  always #5 clk = ~clk;

  exu_longp_oitf_arb #(.OITF_DEPTH(D), .NUM_UNITS(N)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_unit(disp_unit),
    .disp_rdwen(disp_rdwen), .disp_rdidx(disp_rdidx), .disp_itag(disp_itag),
    .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en),
    .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx), .disp_dep(disp_dep),
    .unit_wbck_valid(unit_wbck_valid), .unit_wbck_ready(unit_wbck_ready),
    .unit_wbck_wdat(unit_wbck_wdat), .unit_wbck_itag(unit_wbck_itag),
    .longp_wbck_o_valid(longp_wbck_o_valid), .longp_wbck_o_ready(longp_wbck_o_ready),
    .longp_wbck_o_wdat(longp_wbck_o_wdat), .longp_wbck_o_rdidx(longp_wbck_o_rdidx),
    .oitf_empty(oitf_empty)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dat;
    logic        rdwen;
  } exp_t;

  typedef struct {
    logic       rs1en;
    logic [4:0] rs1;
    logic       rs2en;
    logic [4:0] rs2;
    logic       rdwen;
    logic [4:0] rd;
    logic       dep;
  } hz_t;

  exp_t       sbq[$];
  hz_t        hz_tab[8];
  int         checks = 0;
  int         errors = 0;
  int         cnt;
  logic [1:0] wtag, rtag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] dat(input logic [4:0] rd);
    return 32'hC0DE_0000 | {27'd0, rd};
  endfunction

  task automatic settle();
    #4;
  endtask

  // Scoreboard pop on every retirement, then move to just after the next edge.
  task automatic adv();
    exp_t e;
    if ((longp_wbck_o_valid && longp_wbck_o_ready) || (|unit_wbck_ready)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_retire actual=%0d required=0", sbq.size());
      end else begin
        e = sbq.pop_front();
        chk("retire_is_wbck", longp_wbck_o_valid, e.rdwen);
        if (e.rdwen) begin
          chk("wb_rdidx", longp_wbck_o_rdidx, e.rd);
          chk("wb_wdat", longp_wbck_o_wdat, e.dat);
        end
        cnt--;
        rtag = rtag + 2'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_begin(input logic u, input logic rdwen, input logic [4:0] rd);
    disp_valid = 1'b1;
    disp_unit  = u;
    disp_rdwen = rdwen;
    disp_rdidx = rd;
    settle();
    chk("disp_ready", disp_ready, (cnt < D));
    if (cnt < D) begin
      chk("disp_itag", disp_itag, wtag);
      sbq.push_back('{rd: rd, dat: dat(rd), rdwen: rdwen});
      cnt++;
      wtag = wtag + 2'd1;
    end
  endtask

  task automatic push1(input logic u, input logic rdwen, input logic [4:0] rd);
    push_begin(u, rdwen, rd);
    adv();
    disp_valid = 1'b0;
    disp_rdwen = 1'b0;
  endtask

  task automatic set_ret(input int u, input logic [1:0] tag, input logic [4:0] rd);
    unit_wbck_valid[u]         = 1'b1;
    unit_wbck_itag[u*PW +: PW] = tag;
    unit_wbck_wdat[u*32 +: 32] = dat(rd);
  endtask

  task automatic clr_ret();
    unit_wbck_valid = '0;
  endtask

  // Drain the head through LSU (unit 0) and check it retires.
  task automatic ret_lsu(input logic [4:0] rd);
    set_ret(0, rtag, rd);
    settle();
    chk("drain_unit_ready", unit_wbck_ready, 2'b01);
    adv();
    clr_ret();
  endtask

  initial begin
    hz_tab[0] = '{1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1};
    hz_tab[1] = '{1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0};
    hz_tab[2] = '{1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1};
    hz_tab[3] = '{1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0};
    hz_tab[4] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b1};
    hz_tab[5] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0};
    hz_tab[6] = '{1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd9, 1'b0};
    hz_tab[7] = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0};

    rst = 1'b1;
    disp_valid = 0; disp_unit = 0; disp_rdwen = 0; disp_rdidx = '0;
    disp_rs1en = 0; disp_rs2en = 0; disp_rs1idx = '0; disp_rs2idx = '0;
    unit_wbck_valid = '0; unit_wbck_wdat = '0; unit_wbck_itag = '0;
    longp_wbck_o_ready = 1'b1;
    cnt = 0; wtag = '0; rtag = '0;

    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_empty", oitf_empty, 1'b1);
    chk("rst_disp_ready", disp_ready, 1'b1);
    chk("rst_wbck_valid", longp_wbck_o_valid, 1'b0);
    chk("rst_unit_ready", unit_wbck_ready, 2'b00);
    chk("rst_dep", disp_dep, 1'b0);
    rst = 1'b0;
    adv();

    // Fill: four LSU ops rd=1..4, then a fifth that must be refused.
    for (int i = 1; i <= 4; i++) push1(LONGP_UNIT_LSU[0], 1'b1, 5'(i));
    settle();
    chk("full_disp_ready", disp_ready, 1'b0);
    chk("full_not_empty", oitf_empty, 1'b0);
    adv();
    push1(LONGP_UNIT_LSU[0], 1'b1, 5'd5);

    // Hazard vectors against outstanding rd=1..4.
    for (int i = 0; i < 8; i++) begin
      disp_rs1en = hz_tab[i].rs1en; disp_rs1idx = hz_tab[i].rs1;
      disp_rs2en = hz_tab[i].rs2en; disp_rs2idx = hz_tab[i].rs2;
      disp_rdwen = hz_tab[i].rdwen; disp_rdidx  = hz_tab[i].rd;
      settle();
      chk($sformatf("hz_tab%0d", i), disp_dep, hz_tab[i].dep);
      adv();
    end
    disp_rs1en = 0; disp_rs2en = 0; disp_rdwen = 0;

    for (int i = 1; i <= 4; i++) ret_lsu(5'(i));
    settle();
    chk("fill_drained_empty", oitf_empty, 1'b1);
    adv();

    // Ordering: MULDIV rd=5 is older than LSU rd=6; LSU returns first.
    push1(LONGP_UNIT_MULDIV[0], 1'b1, 5'd5);
    push1(LONGP_UNIT_LSU[0], 1'b1, 5'd6);
    set_ret(0, rtag + 2'd1, 5'd6);
    settle();
    chk("ord_lsu_held_ready", unit_wbck_ready, 2'b00);
    chk("ord_lsu_held_valid", longp_wbck_o_valid, 1'b0);
    adv();
    set_ret(1, rtag, 5'd5);
    settle();
    chk("ord_md_valid", longp_wbck_o_valid, 1'b1);
    chk("ord_md_rdidx", longp_wbck_o_rdidx, 5'd5);
    chk("ord_md_ready", unit_wbck_ready, 2'b10);
    adv();
    unit_wbck_valid[1] = 1'b0;
    settle();
    chk("ord_lsu_valid", longp_wbck_o_valid, 1'b1);
    chk("ord_lsu_ready", unit_wbck_ready, 2'b01);
    adv();
    clr_ret();

    // Backpressure from exu_wbck for three cycles.
    push1(LONGP_UNIT_MULDIV[0], 1'b1, 5'd9);
    set_ret(1, rtag, 5'd9);
    longp_wbck_o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_valid_held", longp_wbck_o_valid, 1'b1);
      chk("bp_unit_ready", unit_wbck_ready, 2'b00);
      chk("bp_not_popped", oitf_empty, 1'b0);
      adv();
    end
    longp_wbck_o_ready = 1'b1;
    settle();
    chk("bp_release_ready", unit_wbck_ready, 2'b10);
    adv();
    clr_ret();
    settle();
    chk("bp_popped_empty", oitf_empty, 1'b1);
    adv();

    // Store entry retires without a register writeback.
    push1(LONGP_UNIT_LSU[0], 1'b0, 5'd7);
    set_ret(0, rtag, 5'd7);
    longp_wbck_o_ready = 1'b0;
    settle();
    chk("st_unit_ready", unit_wbck_ready, 2'b01);
    chk("st_no_wbck", longp_wbck_o_valid, 1'b0);
    adv();
    clr_ret();
    longp_wbck_o_ready = 1'b1;
    settle();
    chk("st_popped_empty", oitf_empty, 1'b1);
    adv();

    // rd=0 writer and a rd=3 store never create dependencies; a rd=3 writer does.
    push1(LONGP_UNIT_LSU[0], 1'b1, 5'd0);
    push1(LONGP_UNIT_LSU[0], 1'b0, 5'd3);
    disp_rs1en = 1'b1; disp_rs1idx = 5'd0;
    settle();
    chk("hz_rd0", disp_dep, 1'b0);
    adv();
    disp_rs1idx = 5'd3;
    settle();
    chk("hz_store_rd3", disp_dep, 1'b0);
    adv();
    disp_rs1en = 1'b0;
    push1(LONGP_UNIT_LSU[0], 1'b1, 5'd3);
    disp_rs1en = 1'b1;
    settle();
    chk("hz_rd3_rs1", disp_dep, 1'b1);
    adv();
    disp_rs1en = 1'b0;
    ret_lsu(5'd0);
    ret_lsu(5'd3);
    ret_lsu(5'd3);

    // Steady push+pop at occupancy 3 across pointer wrap.
    for (int i = 0; i < 3; i++) push1(LONGP_UNIT_LSU[0], 1'b1, 5'(10 + i));
    for (int i = 0; i < 8; i++) begin
      set_ret(0, rtag, 5'(10 + i));
      push_begin(LONGP_UNIT_LSU[0], 1'b1, 5'(13 + i));
      chk("pp_unit_ready", unit_wbck_ready, 2'b01);
      chk("pp_not_empty", oitf_empty, 1'b0);
      adv();
      clr_ret();
      disp_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) ret_lsu(5'(18 + i));
    settle();
    chk("pp_drained_empty", oitf_empty, 1'b1);
    chk("pp_sb_empty", sbq.size(), 0);
    adv();

    // Asynchronous reset with entries outstanding and a head result pending.
    push1(LONGP_UNIT_LSU[0], 1'b1, 5'd12);
    push1(LONGP_UNIT_LSU[0], 1'b1, 5'd13);
    disp_rs1en = 1'b1; disp_rs1idx = 5'd12;
    set_ret(0, rtag, 5'd12);
    longp_wbck_o_ready = 1'b0;
    settle();
    chk("pre_rst_dep", disp_dep, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", oitf_empty, 1'b1);
    chk("mid_rst_disp_ready", disp_ready, 1'b1);
    chk("mid_rst_valid", longp_wbck_o_valid, 1'b0);
    chk("mid_rst_dep", disp_dep, 1'b0);
    chk("mid_rst_unit_ready", unit_wbck_ready, 2'b00);
    sbq.delete();
    cnt = 0; wtag = '0; rtag = '0;
    clr_ret();
    disp_rs1en = 1'b0;
    longp_wbck_o_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push1(LONGP_UNIT_MULDIV[0], 1'b1, 5'd20);
    set_ret(1, rtag, 5'd20);
    settle();
    chk("post_rst_ready", unit_wbck_ready, 2'b10);
    adv();
    clr_ret();
    settle();
    chk("post_rst_empty", oitf_empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=%0t required=<100000", $time);
    $fatal(1);
  end

endmodule
